pc_sequencer: RTL

//  Program-counter controller for the single-cycle core. Owns the PC register and

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_next_calc.sv | 49 ++++
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the program-counter sequencer.
//   seq_state_t : sequencer FSM states (IDLE -> RUN -> DONE -> IDLE)
//   PC_W        : program-counter width
//   LUT_AW      : PC_LUT index width
//   CNT_W       : per-program cycle counter width
package pc_seq_pkg;

    localparam int PC_W   = 12;
    localparam int LUT_AW = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for one RUN cycle.
// Ports:
//   pc_i           current PC
//   lut_target_i   absolute target from PC_LUT
//   offset_i       signed relative branch offset
//   halt_i, stall_i, jump_i, branch_en_i, branch_taken_i   control inputs
//   next_pc_o      PC for the next cycle
//   wrap_o         sequential step ran off the top of the address space
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int D  = PC_W,
    parameter int OW = 8
) (
    input  logic [D-1:0]  pc_i,
    input  logic [D-1:0]  lut_target_i,
    input  logic [OW-1:0] offset_i,
    input  logic          halt_i,
    input  logic          stall_i,
    input  logic          jump_i,
    input  logic          branch_en_i,
    input  logic          branch_taken_i,
    output logic [D-1:0]  next_pc_o,
    output logic          wrap_o
);

    logic [D-1:0] offset_sext;

    assign offset_sext = {{(D-OW){offset_i[OW-1]}}, offset_i};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_pc_o = pc_i;
        wrap_o    = 1'b0;
        if (halt_i || stall_i) begin
            next_pc_o = pc_i;
        end else if (jump_i) begin
            next_pc_o = lut_target_i;
        end else if (branch_en_i && branch_taken_i) begin
            // Relative branches wrap silently modulo 2**D.
            next_pc_o = pc_i + offset_sext;
        end else begin
            next_pc_o = pc_i + D'(1);
            // Only the plain sequential step counts as running off the end.
            wrap_o    = &pc_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: launches programs through PC_LUT, sequences
// jumps, relative branches, stalls and halt, and reports status.
// Ports:
//   Clk, Reset        clock; synchronous active-high reset
//   Start, StartProg  launch request and program number (0 = invalid)
//   Stall, Halt       hold PC / finish program (RUN only)
//   Jump, LutIdx      absolute jump through PC_LUT
//   BranchEn, BranchTaken, Offset   conditional relative branch
//   LutTarget, LutAddr              PC_LUT data / address
//   ProgCtr           current PC
//   Busy, Done        running flag / one-cycle completion pulse
//   Fault             sticky PC-wrap flag, cleared on launch
//   StartErr          one-cycle pulse for a launch with StartProg==0
//   CycleCnt          saturating RUN-cycle count of the current/last program
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D  = PC_W,
    parameter int AW = LUT_AW,
    parameter int OW = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        StartProg,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              Jump,
    input  logic              BranchEn,
    input  logic              BranchTaken,
    input  logic [AW-1:0]     LutIdx,
    input  logic [OW-1:0]     Offset,
    input  logic [D-1:0]      LutTarget,
    output logic [AW-1:0]     LutAddr,
    output logic [D-1:0]      ProgCtr,
    output logic              Busy,
    output logic              Done,
    output logic              Fault,
    output logic              StartErr,
    output logic [CNT_W-1:0]  CycleCnt
);

    seq_state_t       state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             start_err_q, start_err_d;

    logic [D-1:0]     next_pc;
    logic             wrap;

    pc_next_calc #(
        .D  (D),
        .OW (OW)
    ) u_next (
        .pc_i           (pc_q),
        .lut_target_i   (LutTarget),
        .offset_i       (Offset),
        .halt_i         (Halt),
        .stall_i        (Stall),
        .jump_i         (Jump),
        .branch_en_i    (BranchEn),
        .branch_taken_i (BranchTaken),
        .next_pc_o      (next_pc),
        .wrap_o         (wrap)
    );

    // The LUT is looked up in the same cycle: program number while idle,
    // instruction index while running.
    always_comb begin
        LutAddr = '0;
        case (state_q)
            IDLE:    LutAddr = {{(AW-3){1'b0}}, StartProg};
            RUN:     LutAddr = LutIdx;
            default: LutAddr = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        done_d      = 1'b0;
        start_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (StartProg != 3'd0) begin
                        pc_d    = LutTarget;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                pc_d  = next_pc;
                if (Halt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (wrap) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                // PC and count stay frozen for the single DONE cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            start_err_q <= start_err_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign CycleCnt = cnt_q;
    assign Done     = done_q;
    assign Fault    = fault_q;
    assign StartErr = start_err_q;
    assign Busy     = (state_q == RUN);

endmodule
